vmbrew_seq: RTL and testbench

Brew sequencer for the coffee vending machine. It sits between the payment FSM (coin/NFC acceptance) and the brew actuators. It accepts one paid order at a time over a req/ack handshake, checks the water and bean sensors, and drives the grinder, heater and pump through timed phases. It reports completion, aborts and a saturating cup count.

---
 rtl/vmbrew_if.sv | 26 ++
 rtl/vmbrew_seq.sv | 134 +++++++++++++
 tb/tb_vmbrew_seq.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/vmbrew_if.sv
// Handshake and sensor bundle between the payment FSM / sensors and the brew sequencer.
// The payment side (master) drives the order and sensor levels; the sequencer (slave) drives the actuators and status.
interface vmbrew_if;
  logic       REQ;
  logic [4:0] WATER;
  logic       BEANS;
  logic       ACK;
  logic       GRIND;
  logic       HEAT;
  logic       PUMP;
  logic       BUSY;
  logic       DONE;
  logic       ABORT;
  logic       FAULT;
  logic [7:0] CUPS;

  modport master (
    output REQ, WATER, BEANS,
    input  ACK, GRIND, HEAT, PUMP, BUSY, DONE, ABORT, FAULT, CUPS
  );

  modport slave (
    input  REQ, WATER, BEANS,
    output ACK, GRIND, HEAT, PUMP, BUSY, DONE, ABORT, FAULT, CUPS
  );
endinterface

// File: rtl/vmbrew_seq.sv
// Brew sequencer: accepts one paid order, runs timed grind/heat/pump phases,
// aborts on sensor loss and keeps a saturating cup count.
module vmbrew_seq #(
  parameter int GRIND_CYC = 4,
  parameter int HEAT_CYC  = 6,
  parameter int PUMP_CYC  = 5,
  parameter int WATER_MIN = 2
) (
  input  logic    clk,
  input  logic    rst,
  vmbrew_if.slave bus
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_GRIND = 3'd1;
  localparam logic [2:0] S_HEAT  = 3'd2;
  localparam logic [2:0] S_PUMP  = 3'd3;
  localparam logic [2:0] S_FIN   = 3'd4;
  localparam logic [2:0] S_FLT   = 3'd5;

  localparam logic [7:0] GRIND_LOAD = 8'(GRIND_CYC - 1);
  localparam logic [7:0] HEAT_LOAD  = 8'(HEAT_CYC - 1);
  localparam logic [7:0] PUMP_LOAD  = 8'(PUMP_CYC - 1);

  logic [2:0] state_reg, state_next;
  logic [7:0] cnt_reg, cnt_next;
  logic [7:0] cups_reg;
  logic       ack_reg, grind_reg, heat_reg, pump_reg;
  logic       busy_reg, done_reg, abort_reg, fault_reg;
  logic       ok;
  logic       from_ready;

  assign ok = (bus.WATER >= 5'(WATER_MIN)) && bus.BEANS;

  // FIN already counts as back in IDLE for acceptance, so a held REQ
  // starts the next order straight after the DONE cycle.
  assign from_ready = (state_reg == S_IDLE) || (state_reg == S_FIN);

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      S_IDLE, S_FIN: begin
        if (bus.REQ && ok) begin
          state_next = S_GRIND;
          cnt_next   = GRIND_LOAD;
        end else begin
          state_next = S_IDLE;
          cnt_next   = 8'd0;
        end
      end
      S_GRIND: begin
        if (!ok) begin
          state_next = S_FLT;
          cnt_next   = 8'd0;
        end else if (cnt_reg == 8'd0) begin
          state_next = S_HEAT;
          cnt_next   = HEAT_LOAD;
        end else begin
          cnt_next = cnt_reg - 8'd1;
        end
      end
      S_HEAT: begin
        if (!ok) begin
          state_next = S_FLT;
          cnt_next   = 8'd0;
        end else if (cnt_reg == 8'd0) begin
          state_next = S_PUMP;
          cnt_next   = PUMP_LOAD;
        end else begin
          cnt_next = cnt_reg - 8'd1;
        end
      end
      S_PUMP: begin
        // The final pump cycle completes the cup even if a sensor drops.
        if (cnt_reg == 8'd0) begin
          state_next = S_FIN;
        end else if (!ok) begin
          state_next = S_FLT;
          cnt_next   = 8'd0;
        end else begin
          cnt_next = cnt_reg - 8'd1;
        end
      end
      S_FLT: begin
        if (ok && !bus.REQ) state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
        cnt_next   = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= S_IDLE;
      cnt_reg   <= 8'd0;
      cups_reg  <= 8'd0;
      ack_reg   <= 1'b0;
      grind_reg <= 1'b0;
      heat_reg  <= 1'b0;
      pump_reg  <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      abort_reg <= 1'b0;
      fault_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      ack_reg   <= from_ready && (state_next == S_GRIND);
      grind_reg <= (state_next == S_GRIND);
      heat_reg  <= (state_next == S_HEAT);
      pump_reg  <= (state_next == S_PUMP);
      busy_reg  <= (state_next == S_GRIND) || (state_next == S_HEAT) ||
                   (state_next == S_PUMP)  || (state_next == S_FIN);
      done_reg  <= (state_next == S_FIN);
      abort_reg <= (state_next == S_FLT) && (state_reg != S_FLT);
      fault_reg <= (state_next == S_FLT) || ((state_next == S_IDLE) && !ok);
      if ((state_next == S_FIN) && (cups_reg != 8'hFF)) cups_reg <= cups_reg + 8'd1;
    end
  end

  assign bus.ACK   = ack_reg;
  assign bus.GRIND = grind_reg;
  assign bus.HEAT  = heat_reg;
  assign bus.PUMP  = pump_reg;
  assign bus.BUSY  = busy_reg;
  assign bus.DONE  = done_reg;
  assign bus.ABORT = abort_reg;
  assign bus.FAULT = fault_reg;
  assign bus.CUPS  = cups_reg;

endmodule

// File: tb/tb_vmbrew_seq.sv
// Bench for vmbrew_seq: per-cycle comparison against a brew-position model, a
// segment table with hand-derived end states, and hand sequences for timing, reset and saturation.
module tb_vmbrew_seq;
  localparam int G    = 4;
  localparam int H    = 6;
  localparam int P    = 5;
  localparam int WMIN = 2;
  localparam int TOT  = G + H + P;

  logic clk = 1'b0;
  logic rst = 1'b1;
  vmbrew_if bus ();

  vmbrew_seq #(.GRIND_CYC(G), .HEAT_CYC(H), .PUMP_CYC(P), .WATER_MIN(WMIN)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;
  int n_ack   = 0;
  int n_done  = 0;
  int n_abort = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    else n_pass++;
  endtask

  // Model: position within a brew (-1 = not brewing, 0..TOT-1 actuator
  // cycles, TOT = completion cycle) plus a latched fault flag.
  int       m_pos;
  bit       m_flt, m_ack, m_abort, m_fault;
  int       m_cups;

  task automatic model_reset();
    m_pos = -1; m_flt = 0; m_ack = 0; m_abort = 0; m_fault = 0; m_cups = 0;
  endtask

  task automatic model_step(input bit req, input bit ok);
    m_ack = 0;
    m_abort = 0;
    if (m_pos >= 0 && m_pos < TOT) begin
      if (!ok && m_pos != TOT - 1) begin
        m_pos = -1; m_flt = 1; m_abort = 1;
      end else begin
        m_pos++;
        if (m_pos == TOT && m_cups < 255) m_cups++;
      end
    end else if (m_flt) begin
      if (ok && !req) m_flt = 0;
    end else if (req && ok) begin
      m_pos = 0; m_ack = 1;
    end else begin
      m_pos = -1;
    end
    m_fault = m_flt || (m_pos == -1 && !ok);
  endtask

  function automatic logic [15:0] model_vec();
    logic g, h, p;
    g = (m_pos >= 0) && (m_pos < G);
    h = (m_pos >= G) && (m_pos < G + H);
    p = (m_pos >= G + H) && (m_pos < TOT);
    return {m_ack, g, h, p, (m_pos >= 0), (m_pos == TOT), m_abort, m_fault, 8'(m_cups)};
  endfunction

  function automatic logic [15:0] dut_vec();
    return {bus.ACK, bus.GRIND, bus.HEAT, bus.PUMP, bus.BUSY, bus.DONE, bus.ABORT, bus.FAULT, bus.CUPS};
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) model_reset();
    else begin
      cyc++;
      model_step(bus.REQ, (bus.WATER >= 5'(WMIN)) && bus.BEANS);
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("cycle_vs_model", 32'(dut_vec()), 32'(model_vec()));
      chk("actuator_excl", 32'($countones({bus.GRIND, bus.HEAT, bus.PUMP}) <= 1), 32'd1);
      if (bus.ACK)   begin n_ack++;   $display("cycle %0d: order accepted", cyc); end
      if (bus.DONE)  begin n_done++;  $display("cycle %0d: cup done, cups=%0d", cyc, bus.CUPS); end
      if (bus.ABORT) begin n_abort++; $display("cycle %0d: brew aborted", cyc); end
    end
  end

  typedef struct {
    bit       req;
    bit [4:0] water;
    bit       beans;
    int       ncyc;
    bit [2:0] e_act;
    bit       e_busy;
    bit       e_fault;
    bit [7:0] e_cups;
    int       e_acks;
    int       e_dones;
    int       e_aborts;
  } seg_t;

  seg_t tbl [11];

  task automatic drive(input bit req, input bit [4:0] water, input bit beans);
    bus.REQ = req; bus.WATER = water; bus.BEANS = beans;
  endtask

  initial begin
    int a0, d0, b0, lat, gc, hc, pc, waited;
    bit seen;

    tbl[0]  = '{1, 5'd30, 1,  2, 3'b100, 1, 0, 8'd1 - 8'd1, 1, 0, 0};
    tbl[1]  = '{0, 5'd30, 1, 20, 3'b000, 0, 0, 8'd1, 0, 1, 0};
    tbl[2]  = '{1, 5'd1,  1, 10, 3'b000, 0, 1, 8'd1, 0, 0, 0};
    tbl[3]  = '{1, 5'd2,  1,  1, 3'b100, 1, 0, 8'd1, 1, 0, 0};
    tbl[4]  = '{0, 5'd2,  1,  6, 3'b010, 1, 0, 8'd1, 0, 0, 0};
    tbl[5]  = '{0, 5'd2,  0,  1, 3'b000, 0, 1, 8'd1, 0, 0, 1};
    tbl[6]  = '{0, 5'd2,  0,  5, 3'b000, 0, 1, 8'd1, 0, 0, 0};
    tbl[7]  = '{1, 5'd2,  1,  3, 3'b000, 0, 1, 8'd1, 0, 0, 0};
    tbl[8]  = '{0, 5'd2,  1,  1, 3'b000, 0, 0, 8'd1, 0, 0, 0};
    tbl[9]  = '{1, 5'd30, 1, 32, 3'b000, 1, 0, 8'd3, 2, 2, 0};
    tbl[10] = '{0, 5'd30, 1,  3, 3'b000, 0, 0, 8'd3, 0, 0, 0};

    drive(0, 5'd30, 1);
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", 32'(dut_vec()), 32'd0);
    @(negedge clk);
    #1 rst = 1'b0;
    chk("reset_release_outputs", 32'(dut_vec()), 32'd0);

    for (int i = 0; i < 11; i++) begin
      a0 = n_ack; d0 = n_done; b0 = n_abort;
      drive(tbl[i].req, tbl[i].water, tbl[i].beans);
      repeat (tbl[i].ncyc) @(posedge clk);
      @(negedge clk);
      #1;
      $display("segment %0d: req=%0d water=%0d beans=%0d cycles=%0d", i, tbl[i].req, tbl[i].water, tbl[i].beans, tbl[i].ncyc);
      chk($sformatf("seg%0d_act", i),    32'({bus.GRIND, bus.HEAT, bus.PUMP}), 32'(tbl[i].e_act));
      chk($sformatf("seg%0d_busy", i),   32'(bus.BUSY),  32'(tbl[i].e_busy));
      chk($sformatf("seg%0d_fault", i),  32'(bus.FAULT), 32'(tbl[i].e_fault));
      chk($sformatf("seg%0d_cups", i),   32'(bus.CUPS),  32'(tbl[i].e_cups));
      chk($sformatf("seg%0d_acks", i),   32'(n_ack - a0),   32'(tbl[i].e_acks));
      chk($sformatf("seg%0d_dones", i),  32'(n_done - d0),  32'(tbl[i].e_dones));
      chk($sformatf("seg%0d_aborts", i), 32'(n_abort - b0), 32'(tbl[i].e_aborts));
    end

    // Single cup: phase lengths and ACK-to-DONE latency.
    drive(1, 5'd30, 1);
    seen = 0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk); #1;
      seen = bus.ACK;
    end
    chk("ack_seen", 32'(seen), 32'd1);
    bus.REQ = 0;
    lat = 0; gc = int'(bus.GRIND); hc = 0; pc = 0; seen = 0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk); #1;
      lat++;
      gc += int'(bus.GRIND); hc += int'(bus.HEAT); pc += int'(bus.PUMP);
      seen = bus.DONE;
    end
    chk("done_seen", 32'(seen), 32'd1);
    chk("ack_to_done", 32'(lat), 32'(TOT));
    chk("grind_len", 32'(gc), 32'(G));
    chk("heat_len", 32'(hc), 32'(H));
    chk("pump_len", 32'(pc), 32'(P));

    // Asynchronous reset in the middle of the pump phase.
    drive(1, 5'd30, 1);
    seen = 0;
    for (int k = 0; k < 30 && !seen; k++) begin
      @(negedge clk); #1;
      if (bus.ACK) bus.REQ = 0;
      seen = bus.PUMP;
    end
    chk("pump_reached", 32'(seen), 32'd1);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("async_reset_outputs", 32'(dut_vec()), 32'd0);
    @(posedge clk);
    @(negedge clk);
    #1 rst = 1'b0;
    bus.REQ = 0;
    a0 = n_ack;
    repeat (5) @(posedge clk);
    @(negedge clk); #1;
    chk("post_reset_idle_busy", 32'(bus.BUSY), 32'd0);
    chk("post_reset_cups", 32'(bus.CUPS), 32'd0);
    chk("post_reset_no_ack", 32'(n_ack - a0), 32'd0);

    // Saturation: 256 back-to-back cups.
    d0 = n_done;
    drive(1, 5'd30, 1);
    waited = 0;
    while ((n_done - d0) < 256 && waited < 256 * (TOT + 2) + 50) begin
      @(negedge clk); #1;
      waited++;
    end
    bus.REQ = 0;
    chk("sat_done_count", 32'(n_done - d0), 32'd256);
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    chk("sat_cups", 32'(bus.CUPS), 32'd255);

    // Random traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk); #1;
      if ($urandom_range(0, 3) == 0) bus.REQ = ~bus.REQ;
      if ($urandom_range(0, 29) == 0) bus.BEANS = ~bus.BEANS;
      if ($urandom_range(0, 19) == 0) bus.WATER = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 39) == 0) bus.WATER = 5'($urandom_range(WMIN - 1, WMIN));
    end

    drive(0, 5'd30, 1);
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
